vec_alu_sched: RTL and testbench
================================

Name: vec_alu_sched

Overview:
- Issue-side controller for the vector ALU lane array in the picorv32 RVV extension.
- Accepts one vector arithmetic instruction from the core and reads vs2/vs1 from the vector register file.
- Builds the scalar/immediate operand for VX/VI forms, drives the shared run/operand bus to all lanes, and waits until every lane reports done.
- OR-merges lane results, writes vd back, and returns a completion response. One instruction in flight; no overlap.

Parameters:
- VLEN, 128, vector register width in bits.
- NB_LANES_LOG2, 2, log2 of lane count; NL = 1<<NB_LANES_LOG2 lanes (1..8); driven onto alu_nb_lanes.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- resetn  in  1  reset; resetn, synchronous, active-low; clock clk
- issue_valid  in  1  instruction offered
- issue_ready  out  1  high only in IDLE
- issue_opcode  in  6  funct6
- issue_vsew  in  3  element width code, 0..3 legal
- issue_op_type  in  3  001 VV, 010 VX, 100 VI
- issue_vd / issue_vs1 / issue_vs2  in  5 each  register indices
- issue_rs1  in  32  scalar for VX
- issue_imm  in  5  simm5 for VI
- rf_raddr  out  5  VRF read address; data returns 1 cycle later
- rf_rdata  in  VLEN  VRF read data
- rf_we  out  1  VRF write strobe
- rf_waddr  out  5  VRF write address
- rf_wdata  out  VLEN  VRF write data
- alu_run  out  1  run to all lanes
- alu_opcode  out  6  latched opcode
- alu_vsew  out  3  latched vsew
- alu_op_type  out  3  latched op type
- alu_nb_lanes  out  2  NB_LANES_LOG2
- alu_vs1  out  VLEN  vs1 operand
- alu_vs2  out  VLEN  vs2 operand
- lane_vd  in  NL*VLEN  lane results; lane k at [k*VLEN +: VLEN]
- lane_done  in  NL  per-lane done
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all registered outputs 0; state IDLE; issue_ready=1; operand/result registers 0.
- IDLE:
  - On issue_valid&&issue_ready, latch all issue_* fields.
  - vsew>3 or op_type not one-hot: go to RESP with err=1. No VRF access, no run.
  - Otherwise go to RD2.
- RD2: rf_raddr=vs2. Go to RD1.
- RD1: capture rf_rdata into vs2_q; rf_raddr=vs1. Go to OPND.
- OPND, builds vs1_q by op type:
  - VV: vs1_q = rf_rdata.
  - VX: vs1_q = {zeros, sign-extended issue_rs1 to 64 bits} in bits [63:0].
  - VI: same layout, using sign-extended simm5.
  - Go to RUN.
- RUN:
  - alu_run=1; alu_* held constant from the latched values.
  - When &lane_done==1: result_q = bitwise OR of all NL lane_vd slices, captured that cycle. Go to WB.
  - alu_run drops in WB, so lanes clear their state.
- WB: rf_we=1, rf_waddr=vd, rf_wdata=result_q, for exactly one cycle. Go to RESP.
- RESP: resp_valid=1, resp_err=err for one cycle. Go to IDLE; issue_ready high again next cycle.
- Latency: accept at cycle 0 → RD2 at 1 → RD1 at 2 → OPND at 3 → RUN from 4 → WB the cycle after all-done is seen → RESP +1.
- Boundary conditions:
  - Partial lane_done (some lanes early): keep waiting. Done lanes hold their outputs while run stays high.
  - lane_done already all-ones in the first RUN cycle: treat as stale and ignore for that first cycle only.
  - vd == vs1 or vs2: legal, because operands are captured before writeback.
  - issue_valid while busy: ignored; instruction must be held by the core.
  - Reset mid-operation: immediate return to IDLE; rf_we, alu_run and resp_valid are 0 the following cycle; no partial writeback.

Optional Feature:
- Macro VEC_ALU_SCHED_WATCHDOG_EN.
- When defined:
  - A cycle counter runs in RUN.
  - If it reaches TIMEOUT without all-done: drop alu_run, skip WB (no rf_we), go to RESP with err=1.
  - Counter clears on entering RUN.
- When undefined: no counter; RUN waits indefinitely; resp_err is set only by illegal issue.

Test Plan:
- VV vand, vsew=2, vs1 reg=0xFFFF0000_..., vs2 reg=0x12345678_... → NL lanes run; rf_we once, waddr=vd, wdata=0x12340000_...; resp_valid with err=0.
- VX vand, vsew=0, rs1=0x0F, vs2 all 0xAB → alu_vs1[63:0]=0x000000000000000F, upper bits 0.
- VI, imm=5'b10000 → alu_vs1[63:0]=0xFFFFFFFFFFFFFFF0.
- Lanes assert done on staggered cycles 3, 7, 7, 9 after run → WB exactly 1 cycle after cycle 9; lane_vd slices OR-merged correctly.
- Issue vsew=3'b101 → resp_valid+resp_err one cycle after accept; alu_run and rf_we never asserted.
- resetn low during RUN → alu_run=0 next cycle, no rf_we, issue_ready=1; with the watchdog macro defined, lane_done stuck 0 → err response after TIMEOUT cycles.

Source files
------------

// File: rtl/vec_alu_sched.sv
// vec_alu_sched: issue-side controller for the RVV vector ALU lane array (one instruction in flight).
// Optional RUN watchdog is compiled in when VEC_ALU_SCHED_WATCHDOG_EN is defined.
module vec_alu_sched #(
   parameter int VLEN          = 128,
   parameter int NB_LANES_LOG2 = 2,
   parameter int TIMEOUT       = 1024,
   localparam int NL           = 1 << NB_LANES_LOG2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [5:0]       issue_opcode,
   input  logic [2:0]       issue_vsew,
   input  logic [2:0]       issue_op_type,
   input  logic [4:0]       issue_vd,
   input  logic [4:0]       issue_vs1,
   input  logic [4:0]       issue_vs2,
   input  logic [31:0]      issue_rs1,
   input  logic [4:0]       issue_imm,
   output logic [4:0]       rf_raddr,
   input  logic [VLEN-1:0]  rf_rdata,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [VLEN-1:0]  rf_wdata,
   output logic             alu_run,
   output logic [5:0]       alu_opcode,
   output logic [2:0]       alu_vsew,
   output logic [2:0]       alu_op_type,
   output logic [1:0]       alu_nb_lanes,
   output logic [VLEN-1:0]  alu_vs1,
   output logic [VLEN-1:0]  alu_vs2,
   input  logic [NL*VLEN-1:0] lane_vd,
   input  logic [NL-1:0]    lane_done,
   output logic             resp_valid,
   output logic             resp_err,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_RD2 = 3'd1, S_RD1 = 3'd2, S_OPND = 3'd3,
      S_RUN  = 3'd4, S_WB  = 3'd5, S_RESP = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [5:0]        r_opcode;
   logic [2:0]        r_vsew;
   logic [2:0]        r_op_type;
   logic [4:0]        r_vd;
   logic [4:0]        r_vs1;
   logic [4:0]        r_vs2;
   logic [31:0]       r_rs1;
   logic [4:0]        r_imm;
   logic              r_err;
   logic              r_first;
   logic [VLEN-1:0]   r_vs1_q;
   logic [VLEN-1:0]   r_vs2_q;
   logic [VLEN-1:0]   r_result;
   logic              w_illegal;
   logic              w_all_done;
   logic              w_timeout;
   logic [63:0]       w_sext;
   logic [VLEN-1:0]   w_vs1_op;
   logic [VLEN-1:0]   w_merge;

   assign w_illegal = (issue_vsew > 3'd3) ||
                      ((issue_op_type != 3'b001) && (issue_op_type != 3'b010) &&
                       (issue_op_type != 3'b100));
   // A full done vector in the first RUN cycle is left over from the previous instruction.
   assign w_all_done = (&lane_done) && !r_first;

`ifdef VEC_ALU_SCHED_WATCHDOG_EN
   logic [31:0] r_wd_cnt;

   // Watchdog cycle counter: cleared on the way into RUN, counts while in RUN.
   always_ff @(posedge clk) begin
      if (!resetn)
         r_wd_cnt <= 32'd0;
      else if (r_state == S_OPND)
         r_wd_cnt <= 32'd0;
      else if (r_state == S_RUN)
         r_wd_cnt <= r_wd_cnt + 32'd1;
      else
         r_wd_cnt <= r_wd_cnt;
   end

   assign w_timeout = (r_wd_cnt == 32'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (issue_valid)
               w_next = w_illegal ? S_RESP : S_RD2;
            else
               w_next = S_IDLE;
         end
         S_RD2:  w_next = S_RD1;
         S_RD1:  w_next = S_OPND;
         S_OPND: w_next = S_RUN;
         S_RUN: begin
            if (w_all_done)
               w_next = S_WB;
            else if (w_timeout)
               w_next = S_RESP;
            else
               w_next = S_RUN;
         end
         S_WB:   w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Scalar/immediate operand: sign-extended to 64 bits in the low doubleword.
   always_comb begin
      w_sext = 64'd0;
      case (r_op_type)
         3'b010:  w_sext = {{32{r_rs1[31]}}, r_rs1};
         3'b100:  w_sext = {{59{r_imm[4]}}, r_imm};
         default: w_sext = 64'd0;
      endcase
      if (r_op_type == 3'b001)
         w_vs1_op = rf_rdata;
      else
         w_vs1_op = {{(VLEN-64){1'b0}}, w_sext};
   end

   // OR-merge of all lane result slices.
   always_comb begin
      w_merge = '0;
      for (int k = 0; k < NL; k++)
         w_merge = w_merge | lane_vd[k*VLEN +: VLEN];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Instruction latch, operand capture and result capture.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_opcode  <= 6'd0;
         r_vsew    <= 3'd0;
         r_op_type <= 3'd0;
         r_vd      <= 5'd0;
         r_vs1     <= 5'd0;
         r_vs2     <= 5'd0;
         r_rs1     <= 32'd0;
         r_imm     <= 5'd0;
         r_err     <= 1'b0;
         r_first   <= 1'b0;
         r_vs1_q   <= '0;
         r_vs2_q   <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (issue_valid) begin
                  r_opcode  <= issue_opcode;
                  r_vsew    <= issue_vsew;
                  r_op_type <= issue_op_type;
                  r_vd      <= issue_vd;
                  r_vs1     <= issue_vs1;
                  r_vs2     <= issue_vs2;
                  r_rs1     <= issue_rs1;
                  r_imm     <= issue_imm;
                  r_err     <= w_illegal;
               end
            end
            S_RD1: r_vs2_q <= rf_rdata;
            S_OPND: begin
               r_vs1_q <= w_vs1_op;
               r_first <= 1'b1;
            end
            S_RUN: begin
               r_first <= 1'b0;
               if (w_all_done)
                  r_result <= w_merge;
               else if (w_timeout)
                  r_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign issue_ready  = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign rf_raddr     = (r_state == S_RD2) ? r_vs2 : ((r_state == S_RD1) ? r_vs1 : 5'd0);
   assign rf_we        = (r_state == S_WB);
   assign rf_waddr     = r_vd;
   assign rf_wdata     = r_result;
   assign alu_run      = (r_state == S_RUN);
   assign alu_opcode   = r_opcode;
   assign alu_vsew     = r_vsew;
   assign alu_op_type  = r_op_type;
   assign alu_nb_lanes = NB_LANES_LOG2[1:0];
   assign alu_vs1      = r_vs1_q;
   assign alu_vs2      = r_vs2_q;
   assign resp_valid   = (r_state == S_RESP);
   assign resp_err     = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_vec_alu_sched.sv
// Self-checking bench for vec_alu_sched: VRF and lane models, table vectors, random instructions.
module tb_vec_alu_sched;
   localparam int VLEN = 128;
   localparam int NBL  = 2;
   localparam int NL   = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             issue_valid, issue_ready;
   logic [5:0]       issue_opcode;
   logic [2:0]       issue_vsew, issue_op_type;
   logic [4:0]       issue_vd, issue_vs1, issue_vs2, issue_imm;
   logic [31:0]      issue_rs1;
   logic [4:0]       rf_raddr, rf_waddr;
   logic [VLEN-1:0]  rf_rdata, rf_wdata, alu_vs1, alu_vs2;
   logic             rf_we, alu_run, resp_valid, resp_err, busy;
   logic [5:0]       alu_opcode;
   logic [2:0]       alu_vsew, alu_op_type;
   logic [1:0]       alu_nb_lanes;
   logic [NL*VLEN-1:0] lane_vd;
   logic [NL-1:0]    lane_done;

   vec_alu_sched #(.VLEN(VLEN), .NB_LANES_LOG2(NBL), .TIMEOUT(1024)) dut (
      .clk(clk), .resetn(resetn),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
      .issue_vsew(issue_vsew), .issue_op_type(issue_op_type), .issue_vd(issue_vd),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_rs1(issue_rs1), .issue_imm(issue_imm),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vsew(alu_vsew),
      .alu_op_type(alu_op_type), .alu_nb_lanes(alu_nb_lanes), .alu_vs1(alu_vs1),
      .alu_vs2(alu_vs2), .lane_vd(lane_vd), .lane_done(lane_done),
      .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  opc;
      logic [2:0]  vsew;
      logic [2:0]  opt;
      logic [4:0]  vd;
      logic [4:0]  vs1;
      logic [4:0]  vs2;
      logic [31:0] rs1;
      logic [4:0]  imm;
      int          d0;
      int          d1;
      int          d2;
      int          d3;
      bit          exp_err;
   } vec_t;

   logic [VLEN-1:0] vrf [32];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dly [NL];
   int run_cnt = 0;
   logic was_run = 1'b0;

   // observations gathered every cycle by tick()
   int we_cnt, we_cyc, resp_cnt, resp_cyc, run_cyc0;
   logic [4:0] we_addr;
   logic [VLEN-1:0] we_data, run_vs1, run_vs2;
   logic resp_err_seen, run_seen;
   logic [5:0] run_opc;
   logic [2:0] run_vsew, run_opt;

   task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] lane_part(input int k, input logic [VLEN-1:0] v);
      logic [VLEN-1:0] r;
      r = '0;
      for (int j = 0; j < VLEN/32; j++)
         if (j % NL == k) r[j*32 +: 32] = v[j*32 +: 32];
      return r;
   endfunction

   function automatic bit model_illegal(input vec_t v);
      return (v.vsew > 3'd3) || !(v.opt == 3'b001 || v.opt == 3'b010 || v.opt == 3'b100);
   endfunction

   function automatic logic [VLEN-1:0] model_vs1(input vec_t v);
      logic [VLEN-1:0] r;
      longint s;
      r = '0;
      if (v.opt == 3'b001) begin
         r = vrf[v.vs1];
      end else begin
         if (v.opt == 3'b010) s = longint'(signed'(v.rs1));
         else s = longint'(signed'(v.imm));
         r[63:0] = s;
      end
      return r;
   endfunction

   task automatic clear_obs();
      we_cnt = 0; we_cyc = -1; resp_cnt = 0; resp_cyc = -1; run_cyc0 = -1;
      run_seen = 1'b0; resp_err_seen = 1'b0; we_addr = 5'd0; we_data = '0;
      run_vs1 = '0; run_vs2 = '0; run_opc = 6'd0; run_vsew = 3'd0; run_opt = 3'd0;
   endtask

   // One clock: observe outputs before the edge, then update VRF read data and the lane model.
   task automatic tick();
      logic [4:0] ra;
      if (rf_we) begin we_cnt++; we_cyc = cyc; we_addr = rf_waddr; we_data = rf_wdata; end
      if (resp_valid) begin resp_cnt++; resp_cyc = cyc; resp_err_seen = resp_err; end
      if (alu_run && !run_seen) begin
         run_seen = 1'b1; run_cyc0 = cyc; run_vs1 = alu_vs1; run_vs2 = alu_vs2;
         run_opc = alu_opcode; run_vsew = alu_vsew; run_opt = alu_op_type;
      end
      ra = rf_raddr;
      @(posedge clk);
      #1;
      cyc++;
      rf_rdata = vrf[ra];
      if (alu_run) run_cnt = was_run ? run_cnt + 1 : 0;
      else run_cnt = 0;
      was_run = alu_run;
      for (int k = 0; k < NL; k++) begin
         lane_done[k] = alu_run && (run_cnt >= dly[k]);
         lane_vd[k*VLEN +: VLEN] = lane_done[k] ? lane_part(k, alu_vs1 & alu_vs2) : '0;
      end
   endtask

   task automatic run_vec(input vec_t v, input bit hold);
      logic [VLEN-1:0] e_vs1, e_vs2;
      int c, eff, n;
      e_vs1 = model_vs1(v);
      e_vs2 = vrf[v.vs2];
      eff = v.d0;
      if (v.d1 > eff) eff = v.d1;
      if (v.d2 > eff) eff = v.d2;
      if (v.d3 > eff) eff = v.d3;
      if (eff < 1) eff = 1;
      dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2; dly[3] = v.d3;
      clear_obs();
      issue_opcode = v.opc; issue_vsew = v.vsew; issue_op_type = v.opt; issue_vd = v.vd;
      issue_vs1 = v.vs1; issue_vs2 = v.vs2; issue_rs1 = v.rs1; issue_imm = v.imm;
      issue_valid = 1'b1;
      c = cyc;
      tick();
      if (hold) begin
         issue_opcode = ~v.opc; issue_vd = ~v.vd; issue_vs1 = ~v.vs1; issue_vs2 = ~v.vs2;
         issue_rs1 = ~v.rs1; issue_imm = ~v.imm;
      end else begin
         issue_valid = 1'b0;
      end
      n = 0;
      while (resp_cnt == 0 && n < 200) begin tick(); n++; end
      issue_valid = 1'b0;
      chk_i("resp_seen", resp_cnt, 1);
      chk("resp_err", resp_err_seen, v.exp_err);
      chk_i("ready_after", issue_ready, 1);
      if (v.exp_err) begin
         chk_i("err_resp_cycle", resp_cyc, c + 1);
         chk_i("err_no_run", run_seen, 0);
         chk_i("err_no_we", we_cnt, 0);
      end else begin
         chk_i("run_start", run_cyc0, c + 4);
         chk("alu_vs1", run_vs1, e_vs1);
         chk("alu_vs2", run_vs2, e_vs2);
         chk("alu_ctl", {run_opc, run_vsew, run_opt}, {v.opc, v.vsew, v.opt});
         chk_i("we_count", we_cnt, 1);
         chk_i("we_cycle", we_cyc, c + 4 + eff + 1);
         chk("we_addr", we_addr, v.vd);
         chk("we_data", we_data, e_vs1 & e_vs2);
         chk_i("resp_cycle", resp_cyc, c + 4 + eff + 2);
         vrf[v.vd] = e_vs1 & e_vs2;
      end
      tick();
      chk_i("resp_one_pulse", resp_cnt, 1);
   endtask

   initial begin
      vec_t tbl [6];
      vec_t v;
      int n, r;
      tbl[0] = '{6'b001001, 3'd2, 3'b001, 5'd7,  5'd8,  5'd9,  32'd0, 5'd0, 3, 7, 7, 9, 1'b0};
      tbl[1] = '{6'b001001, 3'b101, 3'b001, 5'd7, 5'd8, 5'd9, 32'd0, 5'd0, 1, 1, 1, 1, 1'b1};
      tbl[2] = '{6'b000000, 3'd1, 3'b011, 5'd12, 5'd8, 5'd9, 32'd0, 5'd0, 1, 1, 1, 1, 1'b1};
      tbl[3] = '{6'b001001, 3'd3, 3'b001, 5'd10, 5'd10, 5'd10, 32'd0, 5'd0, 4, 2, 0, 1, 1'b0};
      tbl[4] = '{6'b001011, 3'd2, 3'b010, 5'd11, 5'd0, 5'd10, 32'h8000_0001, 5'd0, 5, 5, 5, 5, 1'b0};
      tbl[5] = '{6'b001001, 3'd0, 3'b000, 5'd13, 5'd1, 5'd2, 32'd0, 5'd0, 1, 1, 1, 1, 1'b1};

      for (int i = 0; i < 32; i++) vrf[i] = {$urandom, $urandom, $urandom, $urandom};
      vrf[1] = {4{32'hFFFF0000}};
      vrf[2] = {4{32'h12345678}};
      vrf[5] = {16{8'hAB}};
      resetn = 1'b0; issue_valid = 1'b0; issue_opcode = 6'd0; issue_vsew = 3'd0;
      issue_op_type = 3'd0; issue_vd = 5'd0; issue_vs1 = 5'd0; issue_vs2 = 5'd0;
      issue_rs1 = 32'd0; issue_imm = 5'd0; rf_rdata = '0; lane_vd = '0; lane_done = '0;
      for (int k = 0; k < NL; k++) dly[k] = 0;
      clear_obs();
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      chk("rst_outs", {issue_ready, busy, rf_we, alu_run, resp_valid, resp_err},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      chk("rst_vs1", alu_vs1, '0);
      chk("rst_wdata", rf_wdata, '0);
      chk_i("nb_lanes", alu_nb_lanes, NBL);

      // vand VV: 0xFFFF0000 & 0x12345678 per word
      run_vec('{6'b001001, 3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 32'd0, 5'd0, 1, 1, 1, 1, 1'b0}, 1'b0);
      chk("vand_wdata", we_data, {4{32'h12340000}});
      // VX with rs1 = 0x0F
      run_vec('{6'b001001, 3'd0, 3'b010, 5'd4, 5'd0, 5'd5, 32'h0000_000F, 5'd0, 2, 0, 1, 2, 1'b0}, 1'b0);
      chk("vx_operand", run_vs1, {64'd0, 64'h0000_0000_0000_000F});
      // VI with simm5 = -16; every lane already done in the first RUN cycle
      run_vec('{6'b001001, 3'd1, 3'b100, 5'd6, 5'd0, 5'd5, 32'd0, 5'b10000, 0, 0, 0, 0, 1'b0}, 1'b1);
      chk("vi_operand", run_vs1, {64'd0, 64'hFFFF_FFFF_FFFF_FFF0});

      for (int i = 0; i < 6; i++) run_vec(tbl[i], i[0]);

      for (int i = 0; i < 25; i++) begin
         v.opc = 6'($urandom);
         v.vsew = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r == 0) v.opt = 3'($urandom_range(0, 7));
         else v.opt = 3'(1 << (r % 3));
         v.vd = 5'($urandom); v.vs1 = 5'($urandom); v.vs2 = 5'($urandom);
         v.rs1 = $urandom; v.imm = 5'($urandom);
         v.d0 = $urandom_range(0, 10); v.d1 = $urandom_range(0, 10);
         v.d2 = $urandom_range(0, 10); v.d3 = $urandom_range(0, 10);
         v.exp_err = model_illegal(v);
         run_vec(v, 1'($urandom_range(0, 1)));
      end

      // reset while lanes are still running: no writeback, no response
      clear_obs();
      for (int k = 0; k < NL; k++) dly[k] = 50;
      issue_opcode = 6'b001001; issue_vsew = 3'd2; issue_op_type = 3'b001;
      issue_vd = 5'd20; issue_vs1 = 5'd21; issue_vs2 = 5'd22;
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      n = 0;
      while (!alu_run && n < 20) begin tick(); n++; end
      chk_i("rst_mid_running", alu_run, 1);
      repeat (3) tick();
      resetn = 1'b0;
      tick();
      chk("rst_mid_outs", {alu_run, rf_we, resp_valid, issue_ready, busy},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      resetn = 1'b1;
      repeat (10) tick();
      chk_i("rst_mid_no_we", we_cnt, 0);
      chk_i("rst_mid_no_resp", resp_cnt, 0);

`ifdef VEC_ALU_SCHED_WATCHDOG_EN
      clear_obs();
      for (int k = 0; k < NL; k++) dly[k] = 100000;
      issue_op_type = 3'b001; issue_vsew = 3'd0; issue_valid = 1'b1;
      n = cyc;
      tick();
      issue_valid = 1'b0;
      r = 0;
      while (resp_cnt == 0 && r < 1200) begin tick(); r++; end
      chk_i("wd_resp_cycle", resp_cyc, n + 4 + 1024);
      chk_i("wd_err", resp_err_seen, 1);
      chk_i("wd_no_we", we_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
